// File: rtl/regfile_pkg.sv
// Shared register-file constants: geometry and write-back requester indices.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam int unsigned WB_N_REQ  = 3;
    localparam int unsigned WB_ALU    = 0;
    localparam int unsigned WB_LOAD   = 1;
    localparam int unsigned WB_MULDIV = 2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: search from ptr, grant the first valid request, report the next pointer.
module wb_rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any,
    output logic [PTR_W-1:0] ptr_next
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = PTR_W'((int'(ptr) + k) % int'(N_REQ));
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
        ptr_next = PTR_W'((int'(grant_idx) + 1) % int'(N_REQ));
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, plus the
// per-register busy scoreboard used by decode to stall on pending destinations.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned N_REQ  = WB_N_REQ,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DATA_W = REG_DATA_W
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_reg,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]       WriteReg,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    Reg_write_Control,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_reg,
    input  logic [ADDR_W-1:0]       chk_reg1,
    input  logic [ADDR_W-1:0]       chk_reg2,
    output logic                    chk_busy1,
    output logic                    chk_busy2,
    output logic                    rsv_err
);

    localparam int unsigned NREGS = 1 << ADDR_W;
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [PTR_W-1:0]  grant_idx;
    logic [N_REQ-1:0]  grant;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [NREGS-1:0]  set_vec;
    logic [NREGS-1:0]  clr_vec;
    logic              rsv_conflict;

    wb_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any),
        .ptr_next  (ptr_next)
    );

    // No handshake can complete while the block is held in reset.
    assign req_ready = Resetn ? grant : '0;
    assign sel_reg   = req_reg[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];

    // Output stage: register 0 completes its handshake but never asserts the write enable.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rr_ptr            <= '0;
            WriteReg          <= '0;
            WriteData         <= '0;
            Reg_write_Control <= 1'b0;
        end else begin
            Reg_write_Control <= 1'b0;
            if (grant_any) begin
                rr_ptr            <= ptr_next;
                WriteReg          <= sel_reg;
                WriteData         <= sel_data;
                Reg_write_Control <= (sel_reg != ADDR_W'(ZERO_REG));
            end
        end
    end

    // Scoreboard next state: a reservation beats a same-cycle write-back clear.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_valid && (rsv_reg != ADDR_W'(ZERO_REG))) begin
            set_vec[rsv_reg] = 1'b1;
        end
        if (Reg_write_Control) begin
            clr_vec[WriteReg] = 1'b1;
        end
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
        rsv_conflict = |(set_vec & busy & ~clr_vec);
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (rsv_conflict) begin
                rsv_err <= 1'b1;
            end
        end
    end

    assign chk_busy1 = busy[chk_reg1];
    assign chk_busy2 = busy[chk_reg2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a cycle-level reference model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned N  = WB_N_REQ;
    localparam int unsigned AW = REG_ADDR_W;
    localparam int unsigned DW = REG_DATA_W;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_reg;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [AW-1:0]     WriteReg;
    logic [DW-1:0]     WriteData;
    logic              Reg_write_Control;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_reg;
    logic [AW-1:0]     chk_reg1;
    logic [AW-1:0]     chk_reg2;
    logic              chk_busy1;
    logic              chk_busy2;
    logic              rsv_err;

    regfile_wb_arbiter dut (
        .Clock             (Clock),
        .Resetn            (Resetn),
        .req_valid         (req_valid),
        .req_reg           (req_reg),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .WriteReg          (WriteReg),
        .WriteData         (WriteData),
        .Reg_write_Control (Reg_write_Control),
        .rsv_valid         (rsv_valid),
        .rsv_reg           (rsv_reg),
        .chk_reg1          (chk_reg1),
        .chk_reg2          (chk_reg2),
        .chk_busy1         (chk_busy1),
        .chk_busy2         (chk_busy2),
        .rsv_err           (rsv_err)
    );

    always #5 Clock = ~Clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: what the spec says the block must hold after each edge.
    int              m_ptr;
    bit [NUM_REGS-1:0] m_busy;
    bit              m_err;
    bit              m_we;
    bit [AW-1:0]     m_wreg;
    bit [DW-1:0]     m_wdata;
    bit              m_known = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (m_ptr + k) % int'(N);
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        int          g;
        logic [N-1:0] exp_rdy;
        int          clr;
        int          r;
        #1;
        g = Resetn ? model_pick() : -1;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (m_known) begin
            chk("chk_busy1", 32'(chk_busy1), 32'(m_busy[chk_reg1]));
            chk("chk_busy2", 32'(chk_busy2), 32'(m_busy[chk_reg2]));
        end
        @(posedge Clock);
        if (!Resetn) begin
            m_ptr = 0; m_busy = '0; m_err = 1'b0;
            m_we = 1'b0; m_wreg = '0; m_wdata = '0;
            m_known = 1'b1;
        end else begin
            clr = m_we ? int'(m_wreg) : -1;
            r   = int'(rsv_reg);
            if (clr >= 0) m_busy[clr] = 1'b0;
            if (rsv_valid && r != 0) begin
                if (m_busy[r]) m_err = 1'b1;
                m_busy[r] = 1'b1;
            end
            if (g >= 0) begin
                m_ptr   = (g + 1) % int'(N);
                m_wreg  = req_reg[g*AW +: AW];
                m_wdata = req_data[g*DW +: DW];
                m_we    = (m_wreg != 0);
            end else begin
                m_we = 1'b0;
            end
        end
        @(negedge Clock);
        if (m_known) begin
            chk("Reg_write_Control", 32'(Reg_write_Control), 32'(m_we));
            chk("WriteReg", 32'(WriteReg), 32'(m_wreg));
            chk("WriteData", WriteData, m_wdata);
            chk("rsv_err", 32'(rsv_err), 32'(m_err));
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_reg[i*AW +: AW] = r;
        req_data[i*DW +: DW] = d;
    endtask

    logic [N-1:0] exp_grants [6];
    logic [AW-1:0] exp_wregs [6];

    initial begin
        exp_grants = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        exp_wregs  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

        Resetn = 1'b0; rsv_valid = 1'b0; rsv_reg = '0; chk_reg1 = 5'd7; chk_reg2 = '0;
        set_req(WB_ALU, 1'b1, 5'd1, 32'h11);
        set_req(WB_LOAD, 1'b1, 5'd2, 32'h22);
        set_req(WB_MULDIV, 1'b1, 5'd3, 32'h33);

        // Reset held with all requesters valid.
        cycle();
        cycle();
        chk("reset_busy7", 32'(chk_busy1), 32'd0);
        chk("reset_we", 32'(Reg_write_Control), 32'd0);
        Resetn = 1'b1;

        // Contention: grants rotate 0,1,2 and writes trail by one cycle.
        for (int c = 0; c < 6; c++) begin
            #1 chk("contention_grant", 32'(req_ready), 32'(exp_grants[c]));
            cycle();
            chk("contention_wreg", 32'(WriteReg), 32'(exp_wregs[c]));
        end
        req_valid = '0;
        cycle();

        // Single ALU write.
        set_req(WB_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 chk("single_ready", 32'(req_ready), 32'h1);
        cycle();
        chk("single_wreg", 32'(WriteReg), 32'd5);
        chk("single_wdata", WriteData, 32'hDEADBEEF);
        chk("single_we", 32'(Reg_write_Control), 32'd1);
        req_valid = '0;
        cycle();
        chk("single_we_drop", 32'(Reg_write_Control), 32'd0);

        // Load to register 0: handshake completes, no write.
        set_req(WB_LOAD, 1'b1, 5'd0, 32'h1234);
        #1 chk("zero_ready", 32'(req_ready), 32'h2);
        cycle();
        chk("zero_we", 32'(Reg_write_Control), 32'd0);
        req_valid = '0;

        // Scoreboard: reserve 7, then mul/div writes 7 while 7 is re-reserved.
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        cycle();
        rsv_valid = 1'b0;
        #1 chk("rsv7_busy", 32'(chk_busy1), 32'd1);
        set_req(WB_MULDIV, 1'b1, 5'd7, 32'hCAFE0007);
        cycle();
        req_valid = '0;
        chk("muldiv_we", 32'(Reg_write_Control), 32'd1);
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        cycle();
        rsv_valid = 1'b0;
        #1 chk("set_wins_busy", 32'(chk_busy1), 32'd1);
        chk("set_wins_err", 32'(rsv_err), 32'd0);
        rsv_valid = 1'b1; rsv_reg = 5'd7;
        cycle();
        rsv_valid = 1'b0;
        chk("double_rsv_err", 32'(rsv_err), 32'd1);

        // Reserve 9, write it back, busy clears two edges after the grant.
        chk_reg2 = 5'd9;
        rsv_valid = 1'b1; rsv_reg = 5'd9;
        cycle();
        rsv_valid = 1'b0;
        set_req(WB_ALU, 1'b1, 5'd9, 32'h99);
        cycle();
        req_valid = '0;
        cycle();
        #1 chk("clear9_busy", 32'(chk_busy2), 32'd0);

        // Reserving register 0 is ignored.
        rsv_valid = 1'b1; rsv_reg = 5'd0; chk_reg2 = 5'd0;
        cycle();
        rsv_valid = 1'b0;

        // Reset mid-operation: grant the load, then reset before the write lands.
        set_req(WB_LOAD, 1'b1, 5'd12, 32'h0C0C);
        rsv_valid = 1'b1; rsv_reg = 5'd12;
        cycle();
        req_valid = '0; rsv_valid = 1'b0;
        Resetn = 1'b0;
        cycle();
        chk("midreset_we", 32'(Reg_write_Control), 32'd0);
        chk("midreset_err", 32'(rsv_err), 32'd0);
        Resetn = 1'b1;
        chk_reg1 = 5'd7; chk_reg2 = 5'd12;
        req_valid = '1;
        #1 chk("midreset_busy7", 32'(chk_busy1), 32'd0);
        chk("midreset_busy12", 32'(chk_busy2), 32'd0);
        chk("midreset_ptr", 32'(req_ready), 32'h1);
        for (int c = 0; c < 4; c++) cycle();
        req_valid = '0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
